// File: rtl/fetch_pkg.sv
// Shared types and constants for the RoadRunner instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned PC_W    = 16;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned CNT_W   = 32;

    localparam logic [PC_W-1:0]    RESET_PC  = 16'h0000;
    localparam logic [3:0]         OPC_HALT  = 4'hF;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    // IF/ID pipeline register payload
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc_plus1;
        logic               valid;
    } ifid_t;

    localparam ifid_t IFID_RST = '{instr: NOP_INSTR, pc_plus1: 16'h0000, valid: 1'b0};

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: 4] == OPC_HALT;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory (slave).
interface instr_fetch_if;

    logic [fetch_pkg::PC_W-1:0]    im_addr;
    logic                          im_rd_en;
    logic [fetch_pkg::INSTR_W-1:0] im_instr;

    modport master (output im_addr, output im_rd_en, input  im_instr);
    modport slave  (input  im_addr, input  im_rd_en, output im_instr);

endinterface

// File: rtl/fetch_perf_cnt.sv
// Saturating event counter with synchronous clear.
module fetch_perf_cnt
    import fetch_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC, next-PC mux, IF/ID register and RUN/HALT FSM.
// Optional perf counters are enabled with FETCH_PERF_CNT_EN.
module instr_fetch
    import fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [PC_W-1:0]      redirect_pc,
    instr_fetch_if.master        imem,
    output logic [INSTR_W-1:0]   ifid_instr,
    output logic [PC_W-1:0]      ifid_pc_plus1,
    output logic                 ifid_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [CNT_W-1:0]     fetch_cnt,
    output logic [CNT_W-1:0]     stall_cnt,
`endif
    output logic                 halted
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    ifid_t           ifid_q, ifid_d;
    logic            halted_q, halted_d;
    logic [PC_W-1:0] pc_plus1;

    assign pc_plus1 = pc_q + PC_W'(1);

    // Priority: flush > stall > advance; reset is applied in the register block.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ifid_d   = ifid_q;
        halted_d = halted_q;

        if (flush) begin
            pc_d         = redirect_pc;
            ifid_d.valid = 1'b0;
            ifid_d.instr = NOP_INSTR;
            state_d      = RUN;
            halted_d     = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (!stall) begin
                        ifid_d.instr    = imem.im_instr;
                        ifid_d.pc_plus1 = pc_plus1;
                        ifid_d.valid    = 1'b1;
                        if (is_halt(imem.im_instr)) begin
                            state_d  = HALT;
                            halted_d = 1'b1;
                        end else begin
                            pc_d = pc_plus1;
                        end
                    end
                end
                HALT: begin
                    ifid_d.valid = 1'b0;
                    ifid_d.instr = NOP_INSTR;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            ifid_q   <= IFID_RST;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ifid_q   <= ifid_d;
            halted_q <= halted_d;
        end
    end

    // Read enable must be settled before clk falls; the memory holds its output when low.
    assign imem.im_addr  = pc_q;
    assign imem.im_rd_en = ~rst & ~stall & (state_q == RUN);

    assign ifid_instr    = ifid_q.instr;
    assign ifid_pc_plus1 = ifid_q.pc_plus1;
    assign ifid_valid    = ifid_q.valid;
    assign halted        = halted_q;

`ifdef FETCH_PERF_CNT_EN
    logic fetch_evt_c;
    logic stall_evt_c;

    assign fetch_evt_c = ~flush & ~stall & (state_q == RUN);
    assign stall_evt_c = ~flush &  stall & (state_q == RUN);

    fetch_perf_cnt u_fetch_cnt (
        .clk (clk),
        .clr (rst),
        .inc (fetch_evt_c),
        .cnt (fetch_cnt)
    );

    fetch_perf_cnt u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .inc (stall_evt_c),
        .cnt (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a negedge-latched memory model.
module tb_instr_fetch;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [15:0] redirect_pc;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus1;
    logic        ifid_valid;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
    int unsigned exp_fetch_cnt = 0;
    int unsigned exp_stall_cnt = 0;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;
    logic        prev_halted = 1'b0;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] instr;
        logic [15:0] pc1;
        logic        valid;
        logic        halted;
    } exp_t;
    exp_t exp_q[$];

    instr_fetch_if bus ();

    instr_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .imem          (bus.master),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus1 (ifid_pc_plus1),
        .ifid_valid    (ifid_valid),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt     (fetch_cnt),
        .stall_cnt     (stall_cnt),
`endif
        .halted        (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h1111;
            16'h0001: return 16'h2222;
            16'h0002: return 16'h3333;
            16'h0010: return 16'hF000;
            default:  return {1'b0, a[2:0], a[11:0]};
        endcase
    endfunction

    // Memory latches on clk low and holds its output when not enabled
    always @(negedge clk) begin
        if (bus.im_rd_en) bus.im_instr <= mem_word(bus.im_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check read enable, push expectation, pop/compare after posedge
    task automatic step(input logic s, input logic f, input logic [15:0] rd,
                        input logic exp_rd_en, input logic [15:0] e_addr,
                        input logic [15:0] e_instr, input logic [15:0] e_pc1,
                        input logic e_valid, input logic e_halted);
        exp_t e;
        stall = s;
        flush = f;
        redirect_pc = rd;
        #1;
        chk("im_rd_en", 32'(bus.im_rd_en), 32'(exp_rd_en));
`ifdef FETCH_PERF_CNT_EN
        if (!f && !prev_halted && s) exp_stall_cnt++;
        if (!f && !prev_halted && !s) exp_fetch_cnt++;
`endif
        exp_q.push_back('{addr: e_addr, instr: e_instr, pc1: e_pc1, valid: e_valid, halted: e_halted});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("im_addr", 32'(bus.im_addr), 32'(e.addr));
        chk("ifid_instr", 32'(ifid_instr), 32'(e.instr));
        chk("ifid_valid", 32'(ifid_valid), 32'(e.valid));
        chk("halted", 32'(halted), 32'(e.halted));
        if (e.valid) chk("ifid_pc_plus1", 32'(ifid_pc_plus1), 32'(e.pc1));
        prev_halted = e.halted;
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt", fetch_cnt, 32'(exp_fetch_cnt));
        chk("stall_cnt", stall_cnt, 32'(exp_stall_cnt));
`endif
    endtask

    task automatic check_reset_state();
        chk("rst_im_addr", 32'(bus.im_addr), 32'h0000);
        chk("rst_im_rd_en", 32'(bus.im_rd_en), 32'h0);
        chk("rst_ifid_instr", 32'(ifid_instr), 32'h0000);
        chk("rst_ifid_pc1", 32'(ifid_pc_plus1), 32'h0000);
        chk("rst_ifid_valid", 32'(ifid_valid), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        prev_halted = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        exp_fetch_cnt = 0;
        exp_stall_cnt = 0;
        chk("rst_fetch_cnt", fetch_cnt, 32'h0);
        chk("rst_stall_cnt", stall_cnt, 32'h0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        redirect_pc = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        rst = 1'b0;

        // Sequential fetch from reset
        step(0, 0, 16'h0, 1, 16'h0001, 16'h1111, 16'h0001, 1, 0);
        step(0, 0, 16'h0, 1, 16'h0002, 16'h2222, 16'h0002, 1, 0);
        step(0, 0, 16'h0, 1, 16'h0003, 16'h3333, 16'h0003, 1, 0);
        step(0, 0, 16'h0, 1, 16'h0004, 16'h3003, 16'h0004, 1, 0);
        step(0, 0, 16'h0, 1, 16'h0005, 16'h4004, 16'h0005, 1, 0);

        // Three stall cycles at pc=0005
        for (int i = 0; i < 3; i++)
            step(1, 0, 16'h0, 0, 16'h0005, 16'h4004, 16'h0005, 1, 0);
        for (int a = 5; a < 16; a++)
            step(0, 0, 16'h0, 1, 16'(a + 1), mem_word(16'(a)), 16'(a + 1), 1, 0);

        // Halt word at 0010; stall ignored while halted
        step(0, 0, 16'h0, 1, 16'h0010, 16'hF000, 16'h0011, 1, 1);
        step(0, 0, 16'h0, 0, 16'h0010, 16'h0000, 16'h0000, 0, 1);
        step(1, 0, 16'h0, 0, 16'h0010, 16'h0000, 16'h0000, 0, 1);

        // Flush out of HALT to 0020
        step(0, 1, 16'h0020, 0, 16'h0020, 16'h0000, 16'h0000, 0, 0);
        step(0, 0, 16'h0, 1, 16'h0021, 16'h0020, 16'h0021, 1, 0);

        // Flush with simultaneous stall to 0040
        step(1, 1, 16'h0040, 0, 16'h0040, 16'h0000, 16'h0000, 0, 0);
        step(0, 0, 16'h0, 1, 16'h0041, 16'h0040, 16'h0041, 1, 0);

        // Halt in the shadow of a taken branch is cancelled
        step(0, 1, 16'h0010, 1, 16'h0010, 16'h0000, 16'h0000, 0, 0);
        step(0, 1, 16'h0030, 1, 16'h0030, 16'h0000, 16'h0000, 0, 0);
        step(0, 0, 16'h0, 1, 16'h0031, 16'h0030, 16'h0031, 1, 0);

        // PC wrap at FFFF
        step(0, 1, 16'hFFFF, 1, 16'hFFFF, 16'h0000, 16'h0000, 0, 0);
        step(0, 0, 16'h0, 1, 16'h0000, 16'h7FFF, 16'h0000, 1, 0);
        step(0, 0, 16'h0, 1, 16'h0001, 16'h1111, 16'h0001, 1, 0);

        // Reset mid-operation discards pending stall and redirect
        rst = 1'b1;
        stall = 1'b1;
        flush = 1'b1;
        redirect_pc = 16'h0055;
        @(posedge clk);
        #1;
        check_reset_state();
        rst = 1'b0;
        step(0, 0, 16'h0, 1, 16'h0001, 16'h1111, 16'h0001, 1, 0);
        step(0, 0, 16'h0, 1, 16'h0002, 16'h2222, 16'h0002, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
